// File: rtl/alu_defs.sv
// Shared ALU definitions: result-mux select codes, shift directions and
// the serial shifter's FSM state encoding.
package alu_defs;

    // Select codes of the ALU result multiplexer.
    typedef enum logic [1:0] {
        ALU_SUM   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_OR    = 2'b10,
        ALU_SHIFT = 2'b11
    } alu_sel_t;

    // Shift direction encoding on the dir input.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Serial shifter states; 2'b11 is unreachable and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/alu_serial_shifter.sv
// Multi-cycle shift unit feeding the shift input of the ALU result mux.
// Shifts one bit per clock; the result stays on shift_out until the next
// accepted start. WIDTH must equal 2**SHAMT_W.
module alu_serial_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [WIDTH-1:0]   shift_out,
    output logic               carry_out,
    output logic               busy,
    output logic               done
);
    import alu_defs::*;

    localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

    shift_state_t       state_reg, state_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic               dir_reg, dir_next;
    logic               arith_reg, arith_next;
    logic               carry_reg, carry_next;

    // One-bit shift of the work register in each direction.
    logic [WIDTH-1:0]   step_left;
    logic [WIDTH-1:0]   step_right;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign step_left[gi] = 1'b0;
            end else begin : g_lmid
                assign step_left[gi] = work_reg[gi-1];
            end
            // MSB fill on a right shift is the old sign only for arithmetic.
            if (gi == WIDTH-1) begin : g_msb
                assign step_right[gi] = arith_reg & work_reg[WIDTH-1];
            end else begin : g_rmid
                assign step_right[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            dir_reg   <= DIR_LEFT;
            arith_reg <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            arith_reg <= arith_next;
            carry_reg <= carry_next;
        end
    end

    // Next-state logic: accept in IDLE or DONE, shift-and-count in SHIFT.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        arith_next = arith_reg;
        carry_next = carry_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    work_next  = in_a;
                    count_next = shamt;
                    dir_next   = dir;
                    arith_next = arith;
                    carry_next = 1'b0;
                    state_next = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (dir_reg == DIR_LEFT) begin
                    work_next  = step_left;
                    carry_next = work_reg[WIDTH-1];
                end else begin
                    work_next  = step_right;
                    carry_next = work_reg[0];
                end
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; no input-to-output paths.
    assign shift_out = work_reg;
    assign carry_out = carry_reg;
    assign busy      = (state_reg == ST_SHIFT);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_alu_serial_shifter.sv
// Self-checking bench for alu_serial_shifter: directed vector table,
// randomized operations against a shift-operator reference model, and
// hand-written multi-cycle sequences (start while busy, back-to-back,
// reset mid-shift).
module tb_alu_serial_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_a;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic [31:0] shift_out;
    logic        carry_out;
    logic        busy;
    logic        done;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic        d;
        logic        ar;
        logic [31:0] exp_res;
        logic        exp_carry;
        int          exp_lat;
    } vec_t;

    alu_serial_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_a      (in_a),
        .shamt     (shamt),
        .dir       (dir),
        .arith     (arith),
        .shift_out (shift_out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain shift operators.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input int s,
                                            input logic d, input logic ar);
        if (!d)      return a << s;
        else if (ar) return 32'($signed(a) >>> s);
        else         return a >> s;
    endfunction

    function automatic logic ref_carry(input logic [31:0] a, input int s, input logic d);
        if (s == 0) return 1'b0;
        if (!d)     return a[32-s];
        return a[s-1];
    endfunction

    // Called #1 after an edge; counts edges until done, bounded.
    task automatic wait_done(input int start_lat, output int lat, output logic seen_busy);
        lat = start_lat;
        seen_busy = 1'b0;
        while (!done && lat < 200) begin
            if (busy) seen_busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
    endtask

    // Launch an operation and check latency, result, carry and hold.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                          input logic d, input logic ar, input logic [31:0] exp_res,
                          input logic exp_c, input int exp_lat);
        int   lat;
        logic seen;
        start = 1'b1; in_a = a; shamt = s; dir = d; arith = ar;
        @(posedge clk); #1;
        start = 1'b0; in_a = ~a; shamt = ~s; dir = ~d; arith = ~ar;
        wait_done(1, lat, seen);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_res"},   shift_out, exp_res);
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        check({tag, "_busy"},  {30'd0, seen, busy}, {30'd0, (s != 0), 1'b0});
        @(posedge clk); #1;
        check({tag, "_hold"},  {done, shift_out}, {1'b0, exp_res});
        $display("[TB] %s a=%h shamt=%0d dir=%0d arith=%0d -> %h carry=%0d lat=%0d",
                 tag, a, s, d, ar, shift_out, carry_out, lat);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat, lat2;
        logic seen;
        logic dn_seen;

        vecs[0] = '{32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0000_0010, 1'b0, 5};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 32};
        vecs[3] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[4] = '{32'h0000_0003, 5'd1,  1'b1, 1'b0, 32'h0000_0001, 1'b1, 2};
        vecs[5] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32};
        vecs[6] = '{32'h8000_0001, 5'd1,  1'b0, 1'b0, 32'h0000_0002, 1'b1, 2};
        vecs[7] = '{32'hF000_0000, 5'd4,  1'b1, 1'b1, 32'hFF00_0000, 1'b0, 5};

        rst = 1'b1; start = 1'b0; in_a = 32'hA5A5_A5A5; shamt = 5'd7; dir = 1'b0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {shift_out[31:0]}, 32'h0);
        check("reset_flags", {29'd0, carry_out, busy, done}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].ar,
                   vecs[i].exp_res, vecs[i].exp_carry, vecs[i].exp_lat);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [4:0]  s;
            logic        d, ar;
            a  = $urandom;
            s  = 5'($urandom_range(0, 31));
            d  = 1'($urandom_range(0, 1));
            ar = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), a, s, d, ar, ref_res(a, s, d, ar),
                   ref_carry(a, s, d), s + 1);
        end

        // Start while busy: a second pulse mid-operation must be ignored.
        start = 1'b1; in_a = 32'h1; shamt = 5'd8; dir = 1'b0; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; in_a = 32'hFFFF_FFFF; shamt = 5'd3; dir = 1'b1; arith = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4, lat, seen);
        check("busy_ign_lat", 32'(lat), 32'd9);
        check("busy_ign_res", shift_out, 32'h0000_0100);
        $display("[TB] start_while_busy -> %h lat=%0d", shift_out, lat);
        @(posedge clk); #1;

        // Back-to-back: start held high from during op1 through its DONE cycle.
        start = 1'b1; in_a = 32'h1; shamt = 5'd4; dir = 1'b0; arith = 1'b0;
        @(posedge clk); #1;
        in_a = 32'hF0; shamt = 5'd4; dir = 1'b1; arith = 1'b0;
        wait_done(1, lat, seen);
        check("b2b_first_res", shift_out, 32'h0000_0010);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, lat2, seen);
        check("b2b_second_lat", 32'(lat2), 32'd5);
        check("b2b_second_res", shift_out, 32'h0000_000F);
        $display("[TB] back_to_back first=lat%0d second -> %h lat=%0d", lat, shift_out, lat2);
        @(posedge clk); #1;

        // Reset during an shamt=20 operation.
        start = 1'b1; in_a = 32'h0000_0003; shamt = 5'd20; dir = 1'b0; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out", shift_out, 32'h0);
        check("midrst_flags", {29'd0, carry_out, busy, done}, 32'h0);
        dn_seen = 1'b0;
        repeat (25) begin
            if (done) dn_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_done", {31'd0, dn_seen}, 32'h0);
        $display("[TB] reset_mid_shift -> out=%h busy=%0d done_seen=%0d", shift_out, busy, dn_seen);
        run_op("post_rst", 32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
